// File: rtl/count_event_fifo_if.sv
// count_event_fifo_if
//   Event output channel of count_event_fifo.
//
//   Handshake: the producer (master) drives evt_valid and evt_data. The consumer
//   (slave) drives evt_ready. A transfer happens on a rising clock edge where
//   evt_valid && evt_ready. While evt_valid && !evt_ready, evt_valid and
//   evt_data stay stable. evt_data is don't-care while evt_valid is low.
//
//   Signals:
//     evt_valid  master->slave  head entry present
//     evt_ready  slave->master  consumer accepts the head entry
//     evt_data   master->slave  {flags[2:0]={disc,match,wrap}, count, ts}
interface count_event_fifo_if #(
  parameter int DW = 15
);
  logic          evt_valid;
  logic          evt_ready;
  logic [DW-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/count_event_fifo.sv
// count_event_fifo
//   Watches a free-running counter value. Each cycle the new sample is compared
//   with the previous one. Wrap, compare-match and discontinuity events are
//   timestamped and queued in a small FIFO, which is drained over a valid/ready
//   channel.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     count_in  monitored count, sampled every cycle
//     cmp_val   compare value (used combinationally in the detect cycle)
//     cmp_en    enables match detection
//     clr_ovf   one-cycle pulse that clears ovf (a drop in the same cycle wins)
//     evt       event channel (master side): evt_valid / evt_ready / evt_data
//     level     current FIFO occupancy, 0..DEPTH
//     ovf       sticky flag: an event was dropped because the FIFO was full
module count_event_fifo #(
  parameter int CNT_W = 4,
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         count_in,
  input  logic [CNT_W-1:0]         cmp_val,
  input  logic                     cmp_en,
  input  logic                     clr_ovf,
  count_event_fifo_if.master       evt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = 3 + CNT_W + TS_W;

  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] prev;
  logic             primed;

  logic [DW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic [CNT_W-1:0] prev_inc;
  logic             changed;
  logic             wrap;
  logic             match;
  logic             disc;
  logic             push;
  logic             pop;
  logic             full;
  logic             store;
  logic             drop;
  logic [DW-1:0]    record;

  // Event detection against the previous sample. Nothing is reported until
  // the first sample after reset has been captured into prev.
  always_comb begin
    prev_inc = prev + CNT_W'(1);
    changed  = (count_in != prev);
    wrap     = (prev == {CNT_W{1'b1}}) && (count_in == '0);
    match    = cmp_en && (count_in == cmp_val) && changed;
    disc     = changed && (count_in != prev_inc);
    push     = primed && (wrap || match || disc);
    record   = {disc, match, wrap, count_in, ts};
  end

  // A full FIFO can still accept a push when the head leaves in the same
  // cycle; only a push into a full FIFO without a pop is dropped.
  always_comb begin
    full  = (level == LW'(DEPTH));
    pop   = evt.evt_valid && evt.evt_ready;
    store = push && (!full || pop);
    drop  = push && full && !pop;
  end

  assign evt.evt_valid = (level != '0);
  assign evt.evt_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts     <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      ts     <= ts + TS_W'(1);
      prev   <= count_in;
      primed <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= record;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({store, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/count_event_fifo.md
Name: count_event_fifo

Overview:
- Downstream consumer of the free-running 4-bit counter output.
- Each cycle, compares the incoming count value against the previous sample and detects wrap, compare-match and discontinuity events (e.g. an upstream counter reset).
- Each event is timestamped and queued in a small FIFO.
- Software or other logic drains the FIFO through a valid/ready interface.

Parameters:
- CNT_W, 4, width of the monitored count.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- TS_W, 8, timestamp width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- count_in  in  CNT_W  count value from the upstream counter, sampled every cycle.
- cmp_val  in  CNT_W  compare value.
- cmp_en  in  1  enables match detection.
- clr_ovf  in  1  one-cycle pulse; clears ovf.
- evt_valid  out  1  head-of-FIFO entry present.
- evt_ready  in  1  consumer accepts the head entry.
- evt_data  out  3+CNT_W+TS_W  {flags[2:0]={disc,match,wrap}, count[CNT_W-1:0], ts[TS_W-1:0]}.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: an event was dropped.

Behaviour:
- Reset:
  - rst_n low immediately forces evt_valid=0, level=0, ovf=0, ts=0, FIFO pointers=0, primed=0.
  - evt_data is don't-care while evt_valid=0.
- Timestamp: ts register increments by 1 every cycle out of reset and wraps modulo 2^TS_W. The first cycle after rst_n rises has ts=0.
- Priming: the first sampled cycle after reset stores count_in into prev, sets primed=1 and generates no event.
- Detection (primed=1), with cur=count_in and prev=last cycle's sample:
  - wrap = (prev==2^CNT_W-1) && (cur==0).
  - match = cmp_en && (cur==cmp_val) && (cur!=prev).
  - disc = (cur!=prev) && (cur!=prev+1 mod 2^CNT_W).
  - cur==prev (stall): no flags.
  - Flags may be set together. At most one record is written per cycle, pushed when any flag is set.
  - Record = {flags, cur, ts of the detect cycle}.
- Latency: an event detected in cycle N is written at the end of cycle N. evt_valid rises in cycle N+1 if the FIFO was empty.
- Output handshake:
  - Pop occurs when evt_valid && evt_ready.
  - evt_data and evt_valid hold stable while evt_valid && !evt_ready.
  - Entries leave in push order.
- Push/pop rules:
  - Not full: the push is stored.
  - Full, with a pop in the same cycle: the push is stored and level stays DEPTH.
  - Full, no pop: the record is dropped and ovf is set to 1.
  - Empty, with a push in the same cycle: no pop (evt_valid was 0). The entry appears next cycle.
  - level updates as +1 (push), -1 (pop), or unchanged (both or neither).
- ovf:
  - Sticky until a clr_ovf pulse.
  - clr_ovf in the same cycle as a drop leaves ovf=1 (set wins).
- cmp_val and cmp_en are sampled combinationally in the detect cycle; a change takes effect that cycle.
- Reset mid-operation: all queued entries are discarded. After rst_n rises, the block re-primes and does not report an event for the first sample.

Test Plan:
1. Reset release, count_in=0,1,…,15,0 (one per cycle), cmp_en=0, evt_ready=1 -> exactly one record {flags=001, count=0, ts=16}. evt_valid is high one cycle, at ts=17. ovf=0.
2. Same stimulus with cmp_en=1, cmp_val=5 -> two records in order: {010,5,5}, then {001,0,16}.
3. Same stimulus with cmp_en=1, cmp_val=0 -> no event at ts=0 (priming); single record {011,0,16}.
4. count_in=3,4,7,7,7,0 with cmp_en=0 -> records {100,7,2} and {100,0,5}; no records for the stalls at ts=3,4.
5. evt_ready=0, six discontinuity events with DEPTH=4 -> level=4; ovf=1 after the 5th event. Raise evt_ready: four records drain in push order, one per cycle, and level returns to 0. Pulse clr_ovf -> ovf=0. Then, with the FIFO full and evt_ready=1, issue a push -> level stays 4 and ovf stays 0.
6. Queue three entries, then assert rst_n low mid-cycle -> evt_valid=0, level=0, ovf=0 without waiting for a clock edge. After release with count_in=9, no event; next count_in=10 produces no event; count_in=2 produces {100,2,2}.
